ram_arbiter: RTL and testbench

Two-port request/acknowledge arbiter and sequencer for the 16-bit byte-addressable main-memory RAM (16-bit address, CE_N/WE_N/byte_op control, asynchronous read, posedge write). It sits between the CPU bus unit (port 0) and the DMA/console engine (port 1). It grants one requester at a time and drives the RAM's control and address inputs from registers. It inserts a configurable number of wait states, returns read data, and rejects odd-address word accesses with a bus-error pulse instead of touching memory.

---
 rtl/ram_arb_pkg.sv | 28 ++
 rtl/ram_arb_pick.sv | 24 ++
 rtl/ram_arbiter.sv | 138 +++++++++++++
 tb/tb_ram_arbiter.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// State encoding, port indices and the wait-state counter width live here.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    localparam int CNT_W = 3;

    typedef struct packed {
        logic        we;
        logic        byte_op;
        logic [15:0] addr;
        logic [15:0] wdata;
    } req_t;

    // A word access must be even-aligned; byte accesses may use either byte.
    function automatic logic misaligned(input logic byte_op, input logic [15:0] addr);
        return !byte_op && addr[0];
    endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational two-way winner select: round-robin on ties when rr=1,
// otherwise the DMA port always wins a tie.
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       rr,
    output logic       valid,
    output logic       winner
);

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        valid  = |req;
        winner = PORT_CPU;
        if (req == 2'b11) begin
            winner = rr ? ~last : PORT_DMA;
        end else if (req[1]) begin
            winner = PORT_DMA;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port request/acknowledge arbiter and sequencer for the byte-addressable
// main-memory RAM; all RAM controls and handshake pulses come from flops.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int WAIT_STATES = 0,
    parameter bit RR          = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic        p0_byte,
    input  logic [15:0] p0_addr,
    input  logic [15:0] p0_wdata,
    output logic        p0_ack,
    output logic        p0_err,
    output logic [15:0] p0_rdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic        p1_byte,
    input  logic [15:0] p1_addr,
    input  logic [15:0] p1_wdata,
    output logic        p1_ack,
    output logic        p1_err,
    output logic [15:0] p1_rdata,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_di,
    input  logic [15:0] ram_do,
    output logic        ram_ce_n,
    output logic        ram_we_n,
    output logic        ram_byte_op,
    output logic        busy
);

    localparam logic [CNT_W-1:0] WS = CNT_W'(WAIT_STATES);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             last;
    logic             owner;
    logic             we_flag;
    logic [1:0]       ack_q;
    logic [1:0]       err_q;
    logic [15:0]      rdata_q [2];
    logic             grant;
    logic             winner;
    req_t             sel;

    ram_arb_pick u_pick (
        .req    ({p1_req, p0_req}),
        .last   (last),
        .rr     (RR),
        .valid  (grant),
        .winner (winner)
    );

    always_comb begin
        sel = '{we: p0_we, byte_op: p0_byte, addr: p0_addr, wdata: p0_wdata};
        if (winner == PORT_DMA) begin
            sel = '{we: p1_we, byte_op: p1_byte, addr: p1_addr, wdata: p1_wdata};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // sees the pre-edge value of every other flop regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            count       <= '0;
            last        <= PORT_CPU;
            owner       <= PORT_CPU;
            we_flag     <= 1'b0;
            ack_q       <= '0;
            err_q       <= '0;
            rdata_q[0]  <= '0;
            rdata_q[1]  <= '0;
            ram_addr    <= '0;
            ram_di      <= '0;
            ram_byte_op <= 1'b0;
            ram_ce_n    <= 1'b1;
            ram_we_n    <= 1'b1;
        end else begin
            // Handshake pulses are single-cycle: cleared on every edge unless re-armed.
            ack_q <= '0;
            err_q <= '0;
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        owner       <= winner;
                        ram_addr    <= sel.addr;
                        ram_di      <= sel.wdata;
                        we_flag     <= sel.we;
                        ram_byte_op <= sel.byte_op;
                        count       <= '0;
                        if (misaligned(sel.byte_op, sel.addr)) begin
                            err_q[winner] <= 1'b1;
                            state         <= ST_DONE;
                        end else begin
                            ram_ce_n <= 1'b0;
                            ram_we_n <= !(sel.we && (WS == '0));
                            state    <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    count <= count + CNT_W'(1);
                    if (count == WS) begin
                        // Closing edge: the RAM write lands now and read data is stable.
                        ram_ce_n      <= 1'b1;
                        ram_we_n      <= 1'b1;
                        ack_q[owner]  <= 1'b1;
                        if (!we_flag) begin
                            rdata_q[owner] <= ram_do;
                        end
                        state <= ST_DONE;
                    end else begin
                        ram_we_n <= !(we_flag && ((count + CNT_W'(1)) == WS));
                    end
                end
                ST_DONE: begin
                    last  <= owner;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign p0_ack   = ack_q[0];
    assign p1_ack   = ack_q[1];
    assign p0_err   = err_q[0];
    assign p1_err   = err_q[1];
    assign p0_rdata = rdata_q[0];
    assign p1_rdata = rdata_q[1];
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: two instances (0 wait states round-robin, 3 wait
// states fixed priority), each on a byte-addressable RAM model.
module tb_ram_arbiter;

    localparam int WS_A = 0;
    localparam int WS_B = 3;

    typedef struct {
        bit          valid;
        bit          we;
        bit          byt;
        logic [15:0] addr;
        logic [15:0] wdata;
    } txn_t;

    typedef struct {
        int          port;
        bit          we;
        bit          byt;
        logic [15:0] addr;
        logic [15:0] wdata;
        bit          exp_err;
        logic [15:0] exp_rd;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        p_req   [2][2];
    logic        p_we    [2][2];
    logic        p_byte  [2][2];
    logic [15:0] p_addr  [2][2];
    logic [15:0] p_wdata [2][2];
    logic        p_ack   [2][2];
    logic        p_err   [2][2];
    logic [15:0] p_rdata [2][2];
    logic [15:0] ram_addr [2];
    logic [15:0] ram_di   [2];
    logic [15:0] ram_do   [2];
    logic        ram_ce_n [2];
    logic        ram_we_n [2];
    logic        ram_byte_op [2];
    logic        busy [2];

    logic [7:0] mem     [2][4096] = '{default: '{default: 8'h00}};
    logic [7:0] ref_mem [2][4096] = '{default: '{default: 8'h00}};
    logic [15:0] mdl_rdata [2][2];
    bit          mdl_last  [2];

    int checks = 0;
    int errors = 0;

    ram_arbiter #(.WAIT_STATES(WS_A), .RR(1'b1)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .p0_req(p_req[0][0]), .p0_we(p_we[0][0]), .p0_byte(p_byte[0][0]),
        .p0_addr(p_addr[0][0]), .p0_wdata(p_wdata[0][0]),
        .p0_ack(p_ack[0][0]), .p0_err(p_err[0][0]), .p0_rdata(p_rdata[0][0]),
        .p1_req(p_req[0][1]), .p1_we(p_we[0][1]), .p1_byte(p_byte[0][1]),
        .p1_addr(p_addr[0][1]), .p1_wdata(p_wdata[0][1]),
        .p1_ack(p_ack[0][1]), .p1_err(p_err[0][1]), .p1_rdata(p_rdata[0][1]),
        .ram_addr(ram_addr[0]), .ram_di(ram_di[0]), .ram_do(ram_do[0]),
        .ram_ce_n(ram_ce_n[0]), .ram_we_n(ram_we_n[0]),
        .ram_byte_op(ram_byte_op[0]), .busy(busy[0])
    );

    ram_arbiter #(.WAIT_STATES(WS_B), .RR(1'b0)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .p0_req(p_req[1][0]), .p0_we(p_we[1][0]), .p0_byte(p_byte[1][0]),
        .p0_addr(p_addr[1][0]), .p0_wdata(p_wdata[1][0]),
        .p0_ack(p_ack[1][0]), .p0_err(p_err[1][0]), .p0_rdata(p_rdata[1][0]),
        .p1_req(p_req[1][1]), .p1_we(p_we[1][1]), .p1_byte(p_byte[1][1]),
        .p1_addr(p_addr[1][1]), .p1_wdata(p_wdata[1][1]),
        .p1_ack(p_ack[1][1]), .p1_err(p_err[1][1]), .p1_rdata(p_rdata[1][1]),
        .ram_addr(ram_addr[1]), .ram_di(ram_di[1]), .ram_do(ram_do[1]),
        .ram_ce_n(ram_ce_n[1]), .ram_we_n(ram_we_n[1]),
        .ram_byte_op(ram_byte_op[1]), .busy(busy[1])
    );

    // RAM model: asynchronous read, posedge write, little-endian byte lanes.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            if (ram_ce_n[i]) ram_do[i] = 16'h0000;
            else if (ram_byte_op[i]) ram_do[i] = {8'h00, mem[i][ram_addr[i][11:0]]};
            else ram_do[i] = {mem[i][{ram_addr[i][11:1], 1'b1}], mem[i][{ram_addr[i][11:1], 1'b0}]};
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!ram_ce_n[i] && !ram_we_n[i]) begin
                if (ram_byte_op[i]) begin
                    mem[i][ram_addr[i][11:0]] <= ram_di[i][7:0];
                end else begin
                    mem[i][{ram_addr[i][11:1], 1'b0}] <= ram_di[i][7:0];
                    mem[i][{ram_addr[i][11:1], 1'b1}] <= ram_di[i][15:8];
                end
            end
        end
    end

    function automatic int ws_of(input int d);
        return (d == 0) ? WS_A : WS_B;
    endfunction

    function automatic bit rr_of(input int d);
        return (d == 0);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0o expected %0o", name, act, exp);
        end
    endtask

    // Reference memory: whole-byte/word semantics straight from the access rules.
    function automatic logic [15:0] model_read(input int d, input txn_t t);
        logic [11:0] a;
        a = t.addr[11:0];
        if (t.byt) return {8'h00, ref_mem[d][a]};
        return {ref_mem[d][{a[11:1], 1'b1}], ref_mem[d][{a[11:1], 1'b0}]};
    endfunction

    function automatic void model_write(input int d, input txn_t t);
        logic [11:0] a;
        a = t.addr[11:0];
        if (t.byt) begin
            ref_mem[d][a] = t.wdata[7:0];
        end else begin
            ref_mem[d][{a[11:1], 1'b0}] = t.wdata[7:0];
            ref_mem[d][{a[11:1], 1'b1}] = t.wdata[15:8];
        end
    endfunction

    task automatic check_reset_state(input int d, input string tag);
        check({tag, "_ce_n"}, ram_ce_n[d], 1);
        check({tag, "_we_n"}, ram_we_n[d], 1);
        check({tag, "_busy"}, busy[d], 0);
        check({tag, "_addr"}, ram_addr[d], 0);
        check({tag, "_di"}, ram_di[d], 0);
        check({tag, "_byte_op"}, ram_byte_op[d], 0);
        check({tag, "_pulses"}, {p_ack[d][0], p_ack[d][1], p_err[d][0], p_err[d][1]}, 0);
        check({tag, "_rdata0"}, p_rdata[d][0], 0);
        check({tag, "_rdata1"}, p_rdata[d][1], 0);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mdl_last[d] = 1'b0;
            mdl_rdata[d][0] = '0;
            mdl_rdata[d][1] = '0;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_idle(input int d);
        int k;
        k = 0;
        @(negedge clk);
        while (busy[d] !== 1'b0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (busy[d] !== 1'b0) check("idle_wait", busy[d], 0);
    endtask

    // Issue up to one transaction per port together; predict order, latency,
    // RAM enable cycles and data from the model, then compare.
    task automatic run_pair(input int d, input txn_t t0, input txn_t t1,
                            output logic [15:0] rd0, output logic [15:0] rd1,
                            output bit er0, output bit er1);
        txn_t        t [2];
        int          order [$];
        int          exp_we [$];
        int          got_we [$];
        int          exp_n [2];
        int          got_n [2];
        bit          exp_err [2];
        bit          got_err [2];
        bit          done [2];
        logic [15:0] exp_rd [2];
        logic [15:0] got_rd [2];
        int          exp_ce, got_ce, e0, w, n;
        t[0] = t0;
        t[1] = t1;
        if (t0.valid && t1.valid) begin
            w = rr_of(d) ? (1 - int'(mdl_last[d])) : 1;
            order.push_back(w);
            order.push_back(1 - w);
        end else if (t0.valid) order.push_back(0);
        else if (t1.valid) order.push_back(1);
        e0 = 1;
        exp_ce = 0;
        foreach (order[k]) begin
            int p;
            p = order[k];
            exp_err[p] = !t[p].byt && t[p].addr[0];
            if (exp_err[p]) begin
                exp_n[p] = e0;
            end else begin
                exp_n[p] = e0 + 1 + ws_of(d);
                exp_ce += 1 + ws_of(d);
                if (t[p].we) begin
                    exp_we.push_back(exp_n[p] - 1);
                    model_write(d, t[p]);
                end else begin
                    mdl_rdata[d][p] = model_read(d, t[p]);
                end
            end
            exp_rd[p] = mdl_rdata[d][p];
            mdl_last[d] = p[0];
            e0 = exp_n[p] + 2;
        end

        wait_idle(d);
        for (int p = 0; p < 2; p++) begin
            done[p] = 1'b0;
            got_err[p] = 1'b0;
            got_rd[p] = '0;
            got_n[p] = 0;
            if (t[p].valid) begin
                p_we[d][p] = t[p].we;
                p_byte[d][p] = t[p].byt;
                p_addr[d][p] = t[p].addr;
                p_wdata[d][p] = t[p].wdata;
                p_req[d][p] = 1'b1;
            end
        end
        n = 0;
        got_ce = 0;
        while (!((done[0] || !t[0].valid) && (done[1] || !t[1].valid)) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (!ram_ce_n[d]) got_ce++;
            if (!ram_we_n[d]) got_we.push_back(n);
            for (int p = 0; p < 2; p++) begin
                if (p_ack[d][p] || p_err[d][p]) begin
                    if (!t[p].valid || done[p]) begin
                        check($sformatf("spurious_pulse_p%0d", p), {p_ack[d][p], p_err[d][p]}, 0);
                    end else begin
                        done[p] = 1'b1;
                        got_n[p] = n;
                        got_err[p] = p_err[d][p];
                        got_rd[p] = p_rdata[d][p];
                        check("ack_err_exclusive", p_ack[d][p] && p_err[d][p], 0);
                        p_req[d][p] = 1'b0;
                    end
                end
            end
        end
        p_req[d][0] = 1'b0;
        p_req[d][1] = 1'b0;
        if (n >= 100) check("completion_timeout", {done[0], done[1]}, {t[0].valid, t[1].valid});
        @(posedge clk);
        #1;
        check("pulse_width", {p_ack[d][0], p_ack[d][1], p_err[d][0], p_err[d][1]}, 0);
        for (int p = 0; p < 2; p++) begin
            if (t[p].valid) begin
                check($sformatf("err_d%0d_p%0d", d, p), got_err[p], exp_err[p]);
                check($sformatf("latency_d%0d_p%0d", d, p), got_n[p], exp_n[p]);
                check($sformatf("rdata_d%0d_p%0d", d, p), got_rd[p], exp_rd[p]);
            end
        end
        check($sformatf("ce_cycles_d%0d", d), got_ce, exp_ce);
        check($sformatf("we_count_d%0d", d), got_we.size(), exp_we.size());
        foreach (exp_we[k]) begin
            if (k < got_we.size()) check($sformatf("we_cycle_d%0d", d), got_we[k], exp_we[k]);
        end
        rd0 = got_rd[0];
        rd1 = got_rd[1];
        er0 = got_err[0];
        er1 = got_err[1];
    endtask

    function automatic txn_t mk(input bit we, input bit byt, input logic [15:0] addr,
                                input logic [15:0] wdata);
        txn_t t;
        t.valid = 1'b1;
        t.we = we;
        t.byt = byt;
        t.addr = addr;
        t.wdata = wdata;
        return t;
    endfunction

    function automatic txn_t none();
        txn_t t;
        t = mk(1'b0, 1'b0, '0, '0);
        t.valid = 1'b0;
        return t;
    endfunction

    initial begin
        vec_t        vecs [$];
        logic [15:0] rd0, rd1;
        bit          er0, er1;
        txn_t        a, b;

        vecs.push_back('{0, 1, 0, 16'o1000, 16'o123456, 0, 16'o000000});
        vecs.push_back('{0, 0, 0, 16'o1000, 16'o000000, 0, 16'o123456});
        vecs.push_back('{0, 0, 0, 16'o1003, 16'o000000, 1, 16'o123456});
        vecs.push_back('{1, 1, 0, 16'o1000, 16'o000000, 0, 16'o000000});
        vecs.push_back('{1, 1, 1, 16'o1001, 16'o000377, 0, 16'o000000});
        vecs.push_back('{1, 0, 0, 16'o1000, 16'o000000, 0, 16'o177400});
        vecs.push_back('{1, 0, 1, 16'o1001, 16'o000000, 0, 16'o000377});
        vecs.push_back('{1, 1, 0, 16'o1005, 16'o111111, 1, 16'o000377});
        vecs.push_back('{1, 0, 0, 16'o1004, 16'o000000, 0, 16'o000000});
        vecs.push_back('{0, 0, 1, 16'o1000, 16'o000000, 0, 16'o000000});
        vecs.push_back('{0, 1, 1, 16'o1000, 16'o000252, 0, 16'o000000});
        vecs.push_back('{0, 0, 0, 16'o1000, 16'o000000, 0, 16'o177652});

        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                p_req[d][p] = 1'b0;
                p_we[d][p] = 1'b0;
                p_byte[d][p] = 1'b0;
                p_addr[d][p] = '0;
                p_wdata[d][p] = '0;
            end
        end
        model_reset();
        #12;
        check_reset_state(0, "reset_a");
        check_reset_state(1, "reset_b");
        @(negedge clk);
        reset_n = 1'b1;

        // Directed single-port vectors on the zero-wait-state instance.
        foreach (vecs[i]) begin
            a = mk(vecs[i].we, vecs[i].byt, vecs[i].addr, vecs[i].wdata);
            if (vecs[i].port == 0) run_pair(0, a, none(), rd0, rd1, er0, er1);
            else run_pair(0, none(), a, rd0, rd1, er0, er1);
            check($sformatf("vec%0d_err", i), (vecs[i].port == 0) ? er0 : er1, vecs[i].exp_err);
            check($sformatf("vec%0d_rdata", i), (vecs[i].port == 0) ? rd0 : rd1, vecs[i].exp_rd);
        end

        // Round-robin stream: both ports hold req for four transactions each.
        begin
            int cnt [2];
            int k, n;
            apply_reset();
            wait_idle(0);
            cnt[0] = 0;
            cnt[1] = 0;
            for (int p = 0; p < 2; p++) begin
                p_we[0][p] = 1'b0;
                p_byte[0][p] = 1'b0;
                p_addr[0][p] = (p == 0) ? 16'o1000 : 16'o1004;
                p_req[0][p] = 1'b1;
            end
            k = 0;
            n = 0;
            while (k < 8 && n < 100) begin
                @(posedge clk);
                #1;
                n++;
                for (int p = 0; p < 2; p++) begin
                    if (p_ack[0][p] || p_err[0][p]) begin
                        check($sformatf("rr_order_%0d", k), p, (k % 2 == 0) ? 1 : 0);
                        check($sformatf("rr_time_%0d", k), n, 2 + 3 * k);
                        check($sformatf("rr_rdata_%0d", k), p_rdata[0][p],
                              model_read(0, mk(1'b0, 1'b0, p_addr[0][p], '0)));
                        mdl_rdata[0][p] = model_read(0, mk(1'b0, 1'b0, p_addr[0][p], '0));
                        mdl_last[0] = p[0];
                        cnt[p]++;
                        if (cnt[p] == 4) p_req[0][p] = 1'b0;
                        k++;
                    end
                end
            end
            p_req[0][0] = 1'b0;
            p_req[0][1] = 1'b0;
            check("rr_stream_acks", k, 8);
        end

        // Three wait states, fixed priority.
        run_pair(1, mk(1'b1, 1'b0, 16'o2000, 16'o011111), none(), rd0, rd1, er0, er1);
        run_pair(1, mk(1'b0, 1'b0, 16'o2000, '0), mk(1'b1, 1'b0, 16'o2000, 16'o055555),
                 rd0, rd1, er0, er1);
        check("fixed_prio_dma_first", rd0, 16'o055555);

        // Reset in the middle of a write's ACCESS phase.
        wait_idle(1);
        p_we[1][0] = 1'b1;
        p_byte[1][0] = 1'b0;
        p_addr[1][0] = 16'o2000;
        p_wdata[1][0] = 16'o077777;
        p_req[1][0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("mid_access_ce_low", ram_ce_n[1], 0);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_state(1, "mid_reset");
        p_req[1][0] = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check("mid_reset_we_n_held", ram_we_n[1], 1);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            check("mid_reset_no_pulse", {p_ack[1][0], p_err[1][0]}, 0);
        end
        run_pair(1, mk(1'b0, 1'b0, 16'o2000, '0), none(), rd0, rd1, er0, er1);
        check("mid_reset_word_kept", rd0, 16'o055555);

        // Randomised traffic on both instances over a small overlapping window.
        for (int it = 0; it < 80; it++) begin
            int d, mode;
            d = it % 2;
            mode = $urandom_range(0, 2);
            a = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   16'o3000 + 16'($urandom_range(0, 15)), 16'($urandom));
            b = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   16'o3000 + 16'($urandom_range(0, 15)), 16'($urandom));
            if (mode == 0) b.valid = 1'b0;
            if (mode == 1) a.valid = 1'b0;
            run_pair(d, a, b, rd0, rd1, er0, er1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
